// File: rtl/logic_unit_sequencer.sv
// logic_unit_sequencer: runs one logic_unit operation per start/done handshake.
// It latches the operands, steps through the phases the op class needs, and
// then holds the captured result and status until the next capture.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; operand and result registers hold
//   S_EXEC | ALUOp/COUNTER driven, phase advances once per cycle
//   S_DONE | one-cycle done pulse; a start here is accepted as in S_IDLE
module logic_unit_sequencer #(
    parameter int SHIFT_PHASES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  logic        flush,
    input  logic [31:0] ALUOut,
    input  logic        OVERFLOW,
    input  logic        ZERO,
    input  logic        Update_UC,
    output logic [31:0] ALUSrcA,
    output logic [31:0] ALUSrcB,
    output logic [4:0]  SHAMT,
    output logic [3:0]  ALUOp,
    output logic [1:0]  COUNTER,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf,
    output logic        zero,
    output logic        take,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SHIFT_LAST = 2'(SHIFT_PHASES - 1);

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [1:0]  phase;
    logic        accept;
    logic        op_illegal;
    logic        is_arith;
    logic        is_shift;
    logic        is_cmp;
    logic [1:0]  last_idx;
    logic        last_phase;

    // Op-class decode of the latched op and acceptance of a new request.
    always_comb begin
        is_arith   = ~op_q[3];
        is_shift   = (op_q[3:2] == 2'b10);
        is_cmp     = (op_q[3:2] == 2'b11) && (op_q != 4'hF);
        last_idx   = is_shift ? SHIFT_LAST : 2'd0;
        last_phase = (phase == last_idx);
        accept     = start && (state != S_EXEC);
        op_illegal = (op == 4'hF);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/drive outputs; flush wins over completion.
    always_comb begin
        state_nxt = state;
        ALUOp     = 4'd0;
        COUNTER   = 2'd0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                done      = (state == S_DONE);
                state_nxt = S_IDLE;
                if (accept) begin
                    state_nxt = op_illegal ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                busy    = 1'b1;
                ALUOp   = op_q;
                COUNTER = phase;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (last_phase) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, phase counter and result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUSrcA <= 32'd0;
            ALUSrcB <= 32'd0;
            SHAMT   <= 5'd0;
            op_q    <= 4'd0;
            phase   <= 2'd0;
            result  <= 32'd0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            take    <= 1'b0;
            err     <= 1'b0;
        end else if (accept) begin
            ALUSrcA <= a;
            ALUSrcB <= b;
            SHAMT   <= shamt;
            op_q    <= op;
            phase   <= 2'd0;
            err     <= op_illegal;
            if (op_illegal) begin
                result <= 32'd0;
                ovf    <= 1'b0;
                zero   <= 1'b0;
                take   <= 1'b0;
            end
        end else if (state == S_EXEC) begin
            if (flush) begin
                phase <= 2'd0;
            end else if (last_phase) begin
                phase  <= 2'd0;
                result <= ALUOut;
                ovf    <= is_arith & OVERFLOW;
                zero   <= ZERO;
                take   <= is_cmp & Update_UC;
            end else begin
                phase <= phase + 2'd1;
            end
        end
    end

endmodule

// File: doc/logic_unit_sequencer.md
# logic_unit_sequencer

Multi-cycle sequencer that sits between the control unit and `logic_unit`. It accepts one operation request at a time through a start/done handshake and latches the operands. It then drives `ALUOp`, `COUNTER`, the operands and `SHAMT` for the number of phases that operation needs. Finally it captures `ALUOut`, `OVERFLOW`, `ZERO` and `Update_UC` into registered results.

## Interface
- `SHIFT_PHASES`, default 3: number of phases for shift ops (RegDesloc load, shift, read). Legal range 2–4.
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request strobe; sampled only while `busy`=0.
- `op` input, 4 bits: operation code.
- `a`, `b` input, 32 bits each: operands.
- `shamt` input, 5 bits: shift amount.
- `flush` input, 1 bit: synchronous abort of an in-flight op.
- `ALUOut` input, 32 bits: result from `logic_unit`.
- `OVERFLOW`, `ZERO`, `Update_UC` input, 1 bit each: status from `logic_unit`.
- `ALUSrcA`, `ALUSrcB` output, 32 bits each: registered operands driven to `logic_unit`.
- `SHAMT` output, 5 bits: registered shift amount.
- `ALUOp` output, 4 bits: registered op during EXEC; 0 otherwise.
- `COUNTER` output, 2 bits: phase index during EXEC; 0 otherwise.
- `busy` output, 1 bit: high from the cycle after `start` is accepted until `done` is asserted.
- `done` output, 1 bit: one-cycle completion pulse.
- `result` output, 32 bits: captured `ALUOut`.
- `ovf` output, 1 bit: captured `OVERFLOW`; arithmetic class only, else 0.
- `zero` output, 1 bit: captured `ZERO`.
- `take` output, 1 bit: captured `Update_UC`; compare class only, else 0.
- `err` output, 1 bit: illegal op flag, valid with `done`.

## Operation
- **Op classes:**
  - 0–7: arithmetic/aux, 1 phase.
  - 8–11: shift, `SHIFT_PHASES` phases.
  - 12–14: compare/branch, 1 phase.
  - 15: illegal.
- **States:** IDLE, EXEC, DONE.
- **IDLE:**
  - On `start`=1, latch `a`, `b`, `shamt` into `ALUSrcA`/`ALUSrcB`/`SHAMT`, and `op` into an internal register.
  - Legal op: go to EXEC with phase=0.
  - Illegal op: go to DONE with `err`=1, `result`=0, all flags 0; `logic_unit` is never driven.
- **EXEC:**
  - `ALUOp` = latched op, `COUNTER` = phase.
  - Phase increments each cycle.
  - On the last phase (phase = N−1), sample `ALUOut` and the status inputs on that clock edge into the result registers, then go to DONE.
- **DONE:**
  - `done`=1 for exactly one cycle, `busy`=0.
  - Next state is IDLE. A `start` in this cycle is accepted exactly as in IDLE (back-to-back), so the next EXEC begins the following cycle.
- **Result registers:** hold their values until the next capture. The `err` flag is cleared on the next accepted start.
- **`flush`:**
  - In EXEC: return to IDLE next cycle, no `done`, results unchanged, `ALUOp`/`COUNTER` back to 0.
  - In IDLE/DONE: ignored. `flush` takes priority over phase completion in the same cycle.
- **`start` while `busy`=1:** ignored; no queuing.
- **Operand registers:** hold their last value outside EXEC.

## Timing
- **Reset (asynchronous, `reset`=0):**
  - State IDLE; every output 0: `ALUSrcA`, `ALUSrcB`, `SHAMT`, `ALUOp`, `COUNTER`, `busy`, `done`, `result`, `ovf`, `zero`, `take`, `err`.
  - Reset mid-EXEC discards the op with no `done`.
- **Latency:** with `start` sampled at edge T, EXEC covers cycles T+1 … T+N, and `done` is high during cycle T+N+1.
  - 1-phase ops: `done` at T+2.
  - Shift ops with default `SHIFT_PHASES`: `done` at T+4.
  - Illegal op: `done` at T+1.
- **`COUNTER`:** counts 0,1,…,N−1, one step per cycle, and never wraps within one op.
- **Throughput:** one op per N+1 cycles when back-to-back.
- **`result`/flags:** update on the same edge that enters DONE, so they are valid when `done`=1.

## Test plan
- **Arithmetic op.** Reset, then `start` with `op`=2, `a`=5, `b`=7. Model returns `ALUOut`=12.
  - Required: `COUNTER`=0 in EXEC for 1 cycle; `done` at T+2 with `result`=12, `ovf`=0, `take`=0.
- **Shift op.** `op`=9, `shamt`=4, `SHIFT_PHASES`=3.
  - Required: `COUNTER` sequence 0,1,2 with `ALUOp`=9; `done` at T+4; `result` equals the model's `ALUOut` at phase 2.
- **Compare op.** `op`=13 with model `Update_UC`=1, `ZERO`=1.
  - Required: `take`=1, `zero`=1, `ovf`=0 with `done`.
  - Then issue `op`=1 with `OVERFLOW`=1: required `ovf`=1, `take`=0.
- **Illegal op, then back-to-back.** `op`=15.
  - Required: `done` at T+1 with `err`=1, `result`=0, and `ALUOp` stays 0.
  - Assert `start` with `op`=0 during that `done` cycle: required EXEC the next cycle, `err` cleared.
- **`start` while busy.** During a shift op, pulse `start` with `op`=0.
  - Required: ignored; a single `done`, and `result` from the shift.
- **Flush and reset mid-op.**
  - `flush` at phase 1 of a shift: IDLE next cycle, no `done`, previous `result` retained.
  - `reset` low mid-EXEC: all outputs 0 immediately, without waiting for a clock edge.
